// File: rtl/di_pkg.sv
// Shared definitions for the device-interface endpoint: word width,
// register map offsets and STATUS bit positions.
package di_pkg;

  localparam int DI_W = 16;

  typedef logic [DI_W-1:0] di_word_t;

  localparam di_word_t DI_REG_DATA     = 16'h0000;
  localparam di_word_t DI_REG_UP_COUNT = 16'h0001;
  localparam di_word_t DI_REG_DN_COUNT = 16'h0002;
  localparam di_word_t DI_REG_STATUS   = 16'h0003;

  localparam int ST_UP_OVF = 0;
  localparam int ST_UP_UNF = 1;
  localparam int ST_DN_OVF = 2;
  localparam int ST_W      = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop of an empty
// FIFO is ignored. clear empties the FIFO and wins over push/pop.
module sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  if_clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge if_clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; reset and clear both empty the FIFO.
  always_ff @(posedge if_clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/di_fifo_terminal.sv
// Device-interface endpoint bridging one endpoint address to an UP FIFO
// (fabric -> host) and a DN FIFO (host -> fabric). All host-facing outputs
// are zero when the endpoint is not addressed so terminals can be OR-ed.
module di_fifo_terminal
  import di_pkg::*;
#(
  parameter logic [15:0] EP_ADDR    = 16'h0010,
  parameter int          DEPTH_LOG2 = 9
) (
  input  logic            if_clock,
  input  logic            reset,
  input  logic [15:0]     diEpAddr,
  input  logic [15:0]     diRegAddr,
  input  logic [15:0]     diRegDataIn,
  input  logic            diWrite,
  input  logic            diRead,
  input  logic            diReset,
  output logic [15:0]     diRegDataOut,
  output logic            rd_ready,
  output logic            wr_ready,
  input  logic            up_we,
  input  logic [15:0]     up_data,
  output logic            dn_valid,
  output logic [15:0]     dn_data,
  input  logic            dn_ready
);

  localparam logic [DEPTH_LOG2:0] CNT_ZERO = '0;
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                 sel;
  logic                 data_sel;
  logic                 stat_sel;
  logic                 pop_now;
  logic                 push_now;
  logic                 dn_pop;

  di_word_t             up_rdata;
  logic                 up_full;
  logic                 up_empty;
  logic [DEPTH_LOG2:0]  up_count;
  logic                 dn_full;
  logic                 dn_empty;
  logic [DEPTH_LOG2:0]  dn_count;

  logic [ST_W-1:0]      status;
  logic [ST_W-1:0]      status_set;
  logic [ST_W-1:0]      status_clr;

  assign sel      = (diEpAddr == EP_ADDR);
  assign data_sel = sel && (diRegAddr == DI_REG_DATA);
  assign stat_sel = sel && (diRegAddr == DI_REG_STATUS);

  // A full DN FIFO still takes a host word when the fabric pops in the same cycle.
  assign dn_pop   = dn_ready && !dn_empty;
  assign pop_now  = data_sel && diRead && !up_empty;
  assign push_now = data_sel && diWrite && (!dn_full || dn_pop);

  sync_fifo #(
    .WIDTH      (DI_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_up_fifo (
    .if_clock (if_clock),
    .reset    (reset),
    .clear    (diReset),
    .push     (up_we),
    .wdata    (up_data),
    .pop      (pop_now),
    .rdata    (up_rdata),
    .full     (up_full),
    .empty    (up_empty),
    .count    (up_count)
  );

  sync_fifo #(
    .WIDTH      (DI_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_dn_fifo (
    .if_clock (if_clock),
    .reset    (reset),
    .clear    (diReset),
    .push     (push_now),
    .wdata    (diRegDataIn),
    .pop      (dn_ready),
    .rdata    (dn_data),
    .full     (dn_full),
    .empty    (dn_empty),
    .count    (dn_count)
  );

  assign dn_valid = !dn_empty;

  always_comb begin
    status_set            = '0;
    status_set[ST_UP_OVF] = up_we && up_full && !pop_now;
    status_set[ST_UP_UNF] = data_sel && diRead && up_empty;
    status_set[ST_DN_OVF] = data_sel && diWrite && dn_full && !dn_pop;
  end

  assign status_clr = (stat_sel && diWrite) ? diRegDataIn[ST_W-1:0] : '0;

  // Sticky error flags: a new event in the same cycle as a clear keeps the bit set.
  always_ff @(posedge if_clock) begin
    if (reset || diReset) begin
      status <= '0;
    end else begin
      status <= (status & ~status_clr) | status_set;
    end
  end

  // Host flow control; the last UP word and last DN slot are withheld while being consumed.
  always_comb begin
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    if (data_sel) begin
      rd_ready = (up_count > (pop_now ? CNT_ONE : CNT_ZERO));
      wr_ready = (dn_count < (push_now ? (CNT_FULL - CNT_ONE) : CNT_FULL));
    end else if (sel) begin
      rd_ready = 1'b1;
      wr_ready = 1'b1;
    end
  end

  // Read-data mux toward the host.
  always_comb begin
    diRegDataOut = '0;
    if (sel) begin
      case (diRegAddr)
        DI_REG_DATA:     diRegDataOut = up_empty ? '0 : up_rdata;
        DI_REG_UP_COUNT: diRegDataOut = DI_W'(up_count);
        DI_REG_DN_COUNT: diRegDataOut = DI_W'(dn_count);
        DI_REG_STATUS:   diRegDataOut = {{(DI_W-ST_W){1'b0}}, status};
        default:         diRegDataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_di_fifo_terminal.sv
// Bench for di_fifo_terminal (4-deep FIFOs): directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_di_fifo_terminal;

  localparam int MDEPTH = 4;

  logic        if_clock;
  logic        reset;
  logic [15:0] diEpAddr;
  logic [15:0] diRegAddr;
  logic [15:0] diRegDataIn;
  logic        diWrite;
  logic        diRead;
  logic        diReset;
  logic [15:0] diRegDataOut;
  logic        rd_ready;
  logic        wr_ready;
  logic        up_we;
  logic [15:0] up_data;
  logic        dn_valid;
  logic [15:0] dn_data;
  logic        dn_ready;

  int ncmp  = 0;
  int nfail = 0;

  logic [15:0] up_q[$];
  logic [15:0] dn_q[$];
  logic [2:0]  m_status;

  di_fifo_terminal #(
    .EP_ADDR    (16'h0010),
    .DEPTH_LOG2 (2)
  ) dut (
    .if_clock     (if_clock),
    .reset        (reset),
    .diEpAddr     (diEpAddr),
    .diRegAddr    (diRegAddr),
    .diRegDataIn  (diRegDataIn),
    .diWrite      (diWrite),
    .diRead       (diRead),
    .diReset      (diReset),
    .diRegDataOut (diRegDataOut),
    .rd_ready     (rd_ready),
    .wr_ready     (wr_ready),
    .up_we        (up_we),
    .up_data      (up_data),
    .dn_valid     (dn_valid),
    .dn_data      (dn_data),
    .dn_ready     (dn_ready)
  );

  initial if_clock = 1'b0;
  always #5 if_clock = ~if_clock;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: predict outputs from the model, check them mid-cycle, then advance the model.
  task automatic tick();
    logic        sel, dsel, pop, dpop, push, up_acc, e_rd, e_wr;
    logic [15:0] e_out;
    logic [2:0]  set, clr;
    sel   = (diEpAddr == 16'h0010);
    dsel  = sel && (diRegAddr == 16'h0000);
    pop   = dsel && diRead && (up_q.size() > 0);
    dpop  = dn_ready && (dn_q.size() > 0);
    push  = dsel && diWrite && ((dn_q.size() < MDEPTH) || dpop);
    e_out = 16'h0000;
    if (sel) begin
      case (diRegAddr)
        16'h0000: if (up_q.size() > 0) e_out = up_q[0];
        16'h0001: e_out = 16'(up_q.size());
        16'h0002: e_out = 16'(dn_q.size());
        16'h0003: e_out = {13'b0, m_status};
        default:  e_out = 16'h0000;
      endcase
    end
    e_rd = sel && (!dsel || (up_q.size() > (pop ? 1 : 0)));
    e_wr = sel && (!dsel || (dn_q.size() < MDEPTH - (push ? 1 : 0)));
    @(negedge if_clock);
    chkb("rd_ready", rd_ready, e_rd);
    chkb("wr_ready", wr_ready, e_wr);
    chk16("diRegDataOut", diRegDataOut, e_out);
    chkb("dn_valid", dn_valid, dn_q.size() > 0);
    if (dn_q.size() > 0) chk16("dn_data", dn_data, dn_q[0]);
    @(posedge if_clock);
    if (reset || diReset) begin
      up_q.delete();
      dn_q.delete();
      m_status = 3'b000;
    end else begin
      set[0] = up_we && (up_q.size() >= MDEPTH) && !pop;
      set[1] = dsel && diRead && (up_q.size() == 0);
      set[2] = dsel && diWrite && (dn_q.size() >= MDEPTH) && !dpop;
      clr    = (sel && diRegAddr == 16'h0003 && diWrite) ? diRegDataIn[2:0] : 3'b000;
      m_status = (m_status & ~clr) | set;
      up_acc = up_we && ((up_q.size() < MDEPTH) || pop);
      if (pop) void'(up_q.pop_front());
      if (up_acc) up_q.push_back(up_data);
      if (dpop) void'(dn_q.pop_front());
      if (push) dn_q.push_back(diRegDataIn);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    diEpAddr    = 16'h0010;
    diRegAddr   = 16'h0000;
    diRegDataIn = 16'h0000;
    diWrite     = 1'b0;
    diRead      = 1'b0;
    diReset     = 1'b0;
    up_we       = 1'b0;
    up_data     = 16'h0000;
    dn_ready    = 1'b0;
    up_q.delete();
    dn_q.delete();
    m_status    = 3'b000;
    @(posedge if_clock);
    #1;
    reset = 1'b0;

    // Scenario 1: post-reset state.
    #1;
    chkb("t1_rd_ready", rd_ready, 1'b0);
    chkb("t1_wr_ready", wr_ready, 1'b1);
    chk16("t1_data", diRegDataOut, 16'h0000);
    diRegAddr = 16'h0001;
    #1;
    chk16("t1_up_count", diRegDataOut, 16'h0000);
    tick();

    // Scenario 2: fabric fills UP, host drains it in a burst.
    diRegAddr = 16'h0000;
    up_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_data = 16'hA000 + 16'(i);
      tick();
    end
    up_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      diRead = 1'b1;
      #1;
      chk16("t2_word", diRegDataOut, 16'hA000 + 16'(i));
      chkb("t2_rd_ready", rd_ready, i < 3);
      tick();
    end
    diRead = 1'b0;
    diRegAddr = 16'h0003;
    #1;
    chk16("t2_status", diRegDataOut, 16'h0000);
    tick();

    // Scenario 3: host overfills DN, fabric drains it.
    do_reset();
    diRegAddr = 16'h0000;
    diWrite = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      diRegDataIn = 16'(i);
      #1;
      chkb("t3_wr_ready", wr_ready, i < 4);
      tick();
    end
    diWrite = 1'b0;
    diRegAddr = 16'h0003;
    #1;
    chk16("t3_status", diRegDataOut, 16'h0004);
    diRegAddr = 16'h0002;
    #1;
    chk16("t3_dn_count", diRegDataOut, 16'h0004);
    dn_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chkb("t3_dn_valid", dn_valid, 1'b1);
      chk16("t3_dn_data", dn_data, 16'(i));
      tick();
    end
    dn_ready = 1'b0;
    #1;
    chkb("t3_dn_empty", dn_valid, 1'b0);

    // Scenario 4: UP full with simultaneous push and pop.
    do_reset();
    diRegAddr = 16'h0000;
    up_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_data = 16'hC000 + 16'(i);
      tick();
    end
    up_data = 16'hC004;
    diRead = 1'b1;
    #1;
    chk16("t4_oldest", diRegDataOut, 16'hC000);
    tick();
    up_we = 1'b0;
    diRead = 1'b0;
    diRegAddr = 16'h0001;
    #1;
    chk16("t4_count", diRegDataOut, 16'h0004);
    diRegAddr = 16'h0003;
    #1;
    chk16("t4_status", diRegDataOut, 16'h0000);
    diRegAddr = 16'h0000;
    #1;
    chk16("t4_next", diRegDataOut, 16'hC001);
    tick();

    // Scenario 5: sticky STATUS, write-1-to-clear racing a new error.
    do_reset();
    diRegAddr = 16'h0000;
    diRead = 1'b1;
    tick();
    diRead = 1'b0;
    diRegAddr = 16'h0003;
    #1;
    chk16("t5_unf", diRegDataOut, 16'h0002);
    diRegAddr = 16'h0000;
    diWrite = 1'b1;
    for (int i = 0; i < 5; i++) begin
      diRegDataIn = 16'h0010 + 16'(i);
      tick();
    end
    diWrite = 1'b0;
    diRegAddr = 16'h0003;
    #1;
    chk16("t5_dn_ovf", diRegDataOut, 16'h0006);
    up_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_data = 16'($urandom);
      tick();
    end
    diWrite = 1'b1;
    diRegDataIn = 16'h0007;
    tick();
    up_we = 1'b0;
    diWrite = 1'b0;
    #1;
    chk16("t5_set_wins", diRegDataOut, 16'h0001);
    diWrite = 1'b1;
    tick();
    diWrite = 1'b0;
    #1;
    chk16("t5_cleared", diRegDataOut, 16'h0000);

    // Scenario 6: diReset during a burst while another endpoint is addressed.
    do_reset();
    diRegAddr = 16'h0000;
    diRead = 1'b1;
    tick();
    diRead = 1'b0;
    up_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_data = 16'hD000 + 16'(i);
      tick();
    end
    up_we = 1'b0;
    diWrite = 1'b1;
    diRegDataIn = 16'h0055;
    tick();
    diRegDataIn = 16'h0066;
    tick();
    diWrite = 1'b0;
    diRead = 1'b1;
    tick();
    diEpAddr = 16'h0020;
    #1;
    chk16("t6_other_data", diRegDataOut, 16'h0000);
    chkb("t6_other_rd", rd_ready, 1'b0);
    chkb("t6_other_wr", wr_ready, 1'b0);
    tick();
    diReset = 1'b1;
    #1;
    chk16("t6_rst_data", diRegDataOut, 16'h0000);
    chkb("t6_rst_rd", rd_ready, 1'b0);
    tick();
    diReset = 1'b0;
    tick();
    diRead = 1'b0;
    diEpAddr = 16'h0010;
    diRegAddr = 16'h0001;
    #1;
    chk16("t6_up_count", diRegDataOut, 16'h0000);
    diRegAddr = 16'h0002;
    #1;
    chk16("t6_dn_count", diRegDataOut, 16'h0000);
    diRegAddr = 16'h0003;
    #1;
    chk16("t6_status", diRegDataOut, 16'h0000);
    chkb("t6_dn_valid", dn_valid, 1'b0);
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      int ra;
      diEpAddr    = ($urandom_range(0, 9) == 0) ? 16'h0020 : 16'h0010;
      ra          = $urandom_range(0, 8);
      diRegAddr   = (ra > 4) ? 16'h0000 : 16'(ra);
      diRead      = 1'($urandom);
      diWrite     = 1'($urandom);
      diRegDataIn = 16'($urandom);
      up_we       = 1'($urandom);
      up_data     = 16'($urandom);
      dn_ready    = 1'($urandom);
      diReset     = ($urandom_range(0, 59) == 0);
      reset       = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset    = 1'b0;
    diReset  = 1'b0;
    diRead   = 1'b0;
    diWrite  = 1'b0;
    up_we    = 1'b0;
    dn_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
